// File: rtl/ddr_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_req_arbiter
//  Description : Shares one DDR request channel between the instruction-fetch
//                port (burst reads) and the data-memory port (single reads and
//                writes). Round-robin grant, one transaction outstanding,
//                response routing back to the owner and a hung-DDR timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr_req_arbiter #(
   parameter int ADDR_W      = 64,
   parameter int DATA_W      = 512,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic              clock,
   input  logic              reset_n,
   // instruction fetch port
   input  logic              if_req_valid,
   output logic              if_req_ready,
   input  logic [ADDR_W-1:0] if_req_index,
   output logic              if_resp_valid,
   output logic [DATA_W-1:0] if_resp_data,
   // data memory port
   input  logic              dm_req_valid,
   output logic              dm_req_ready,
   input  logic [ADDR_W-1:0] dm_req_index,
   input  logic              dm_req_write,
   input  logic [DATA_W-1:0] dm_req_wdata,
   output logic              dm_resp_valid,
   output logic [DATA_W-1:0] dm_resp_data,
   output logic              resp_err,
   // DDR channel
   output logic              ddr_chip_enable,
   output logic [ADDR_W-1:0] ddr_index,
   output logic              ddr_write_enable,
   output logic              ddr_burst_mode,
   output logic [DATA_W-1:0] ddr_write_data,
   input  logic [DATA_W-1:0] ddr_read_data,
   input  logic              ddr_operation_done,
   input  logic              ddr_ready
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   // Counter only has to reach TIMEOUT_CYC-1; width never drops below 1 bit.
   localparam int   CNT_W   = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
   localparam int   TO_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
   localparam logic OWN_IF  = 1'b0;
   localparam logic OWN_DM  = 1'b1;

   state_t            state;
   state_t            state_nxt;
   logic              grant_if;
   logic              grant_dm;
   logic              timeout_hit;
   logic              owner;
   logic              last_grant;
   logic              err_flag;
   logic [CNT_W-1:0]  to_cnt;
   logic [ADDR_W-1:0] req_index;
   logic              req_write;
   logic [DATA_W-1:0] req_wdata;
   logic [DATA_W-1:0] if_data_q;
   logic [DATA_W-1:0] dm_data_q;
   logic              chan_active;

   // Last WAIT cycle allowed before the transaction is declared hung.
   assign timeout_hit = (TIMEOUT_CYC != 0) && (to_cnt == CNT_W'(TO_LAST));

   // Round-robin grant: a lone requester wins, a tie goes to whoever did not win last.
   always_comb begin
      grant_if = 1'b0;
      grant_dm = 1'b0;
      if (reset_n && (state == ST_IDLE) && ddr_ready) begin
         if (if_req_valid && (!dm_req_valid || (last_grant == OWN_DM))) begin
            grant_if = 1'b1;
         end else if (dm_req_valid) begin
            grant_dm = 1'b1;
         end
      end
   end

   // Next-state logic for the single-outstanding transaction sequence.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (grant_if || grant_dm) state_nxt = ST_ISSUE;
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT:  if (ddr_operation_done || timeout_hit) state_nxt = ST_RESP;
         ST_RESP:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // State register; reset drops any in-flight transaction without a response.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Request latch, timeout counter, response capture and round-robin history.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         owner      <= OWN_IF;
         last_grant <= OWN_DM;
         err_flag   <= 1'b0;
         to_cnt     <= '0;
         req_index  <= '0;
         req_write  <= 1'b0;
         req_wdata  <= '0;
         if_data_q  <= '0;
         dm_data_q  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_if) begin
                  owner     <= OWN_IF;
                  req_index <= if_req_index;
                  req_write <= 1'b0;
                  req_wdata <= '0;
               end else if (grant_dm) begin
                  owner     <= OWN_DM;
                  req_index <= dm_req_index;
                  req_write <= dm_req_write;
                  req_wdata <= dm_req_write ? dm_req_wdata : '0;
               end
            end
            ST_ISSUE: begin
               to_cnt   <= '0;
               err_flag <= 1'b0;
            end
            ST_WAIT: begin
               if (ddr_operation_done) begin
                  err_flag <= 1'b0;
                  if (owner == OWN_IF) begin
                     if_data_q <= ddr_read_data;
                  end else begin
                     dm_data_q <= req_write ? '0 : ddr_read_data;
                  end
               end else if (timeout_hit) begin
                  err_flag <= 1'b1;
                  if (owner == OWN_IF) begin
                     if_data_q <= '0;
                  end else begin
                     dm_data_q <= '0;
                  end
               end else begin
                  to_cnt <= to_cnt + CNT_W'(1);
               end
            end
            ST_RESP: begin
               last_grant <= owner;
            end
            default: ;
         endcase
      end
   end

   // The DDR fields are only driven while the channel is issuing or waiting.
   assign chan_active      = (state == ST_ISSUE) || (state == ST_WAIT);
   assign ddr_chip_enable  = (state == ST_ISSUE);
   assign ddr_index        = chan_active ? req_index : '0;
   assign ddr_write_enable = chan_active && req_write;
   assign ddr_burst_mode   = chan_active && (owner == OWN_IF);
   assign ddr_write_data   = chan_active ? req_wdata : '0;

   assign if_req_ready  = grant_if;
   assign dm_req_ready  = grant_dm;
   assign if_resp_valid = reset_n && (state == ST_RESP) && (owner == OWN_IF);
   assign dm_resp_valid = reset_n && (state == ST_RESP) && (owner == OWN_DM);
   assign resp_err      = reset_n && (state == ST_RESP) && err_flag;
   assign if_resp_data  = if_data_q;
   assign dm_resp_data  = dm_data_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddr_req_arbiter
//  Description : Directed bench for ddr_req_arbiter with a timeline-level
//                reference model, a DDR responder and event logs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_req_arbiter;

   localparam int AW = 64;
   localparam int DW = 512;
   localparam int TO = 8;
   localparam logic [DW-1:0] GARBAGE = {16{32'hDEADBEEF}};

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_valid, if_ready, if_rv, dm_valid, dm_ready, dm_write, dm_rv, r_err;
   logic [AW-1:0] if_idx, dm_idx, d_idx;
   logic [DW-1:0] if_rdata, dm_wdata, dm_rdata, d_wdata, ddr_rdata;
   logic          d_ce, d_we, d_burst, ddr_done, ddr_rdy;

   ddr_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
      .clock(clk), .reset_n(rst_n),
      .if_req_valid(if_valid), .if_req_ready(if_ready), .if_req_index(if_idx),
      .if_resp_valid(if_rv), .if_resp_data(if_rdata),
      .dm_req_valid(dm_valid), .dm_req_ready(dm_ready), .dm_req_index(dm_idx),
      .dm_req_write(dm_write), .dm_req_wdata(dm_wdata),
      .dm_resp_valid(dm_rv), .dm_resp_data(dm_rdata), .resp_err(r_err),
      .ddr_chip_enable(d_ce), .ddr_index(d_idx), .ddr_write_enable(d_we),
      .ddr_burst_mode(d_burst), .ddr_write_data(d_wdata),
      .ddr_read_data(ddr_rdata), .ddr_operation_done(ddr_done), .ddr_ready(ddr_rdy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   // Cycle index used to timestamp logged events.
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] i);
      return {8{i ^ 64'h0123_4567_89AB_CDEF}};
   endfunction

   typedef struct { int cyc; bit dm; } grant_t;
   typedef struct { int cyc; logic [AW-1:0] idx; bit we; bit burst; logic [DW-1:0] wd; } ce_t;
   typedef struct { int cyc; bit dm; bit err; logic [DW-1:0] data; } resp_t;
   grant_t grant_q[$];
   ce_t    ce_q[$];
   resp_t  resp_q[$];

   // ---------------- DDR responder ----------------
   int ddr_lat     = 5;     // cycles from CE to done; 0 = never answer
   bit inject_done = 1'b0;  // one stray done pulse on the next cycle

   initial begin
      int rem;
      logic [AW-1:0] rd_idx;
      rem = -1;
      rd_idx = '0;
      ddr_done = 1'b0;
      ddr_rdata = GARBAGE;
      forever begin
         @(posedge clk); #2;
         ddr_done = 1'b0;
         ddr_rdata = GARBAGE;
         if (inject_done) begin
            inject_done = 1'b0;
            ddr_done = 1'b1;
            ddr_rdata = pat(64'hBAD);
         end else if (d_ce) begin
            rem = (ddr_lat == 0) ? -1 : ddr_lat;
            rd_idx = d_idx;
         end else if (rem > 0) begin
            rem--;
            if (rem == 0) begin
               ddr_done = 1'b1;
               ddr_rdata = pat(rd_idx);
            end
         end
      end
   end

   // ---------------- reference model + per-cycle compare ----------------
   // Transaction timeline by age: 0 = accept, 1 = CE, >=2 = waiting,
   // resolve age + 1 = response, then free again.
   bit            model_on = 1'b0;
   bit            m_busy, m_last_dm, m_own_dm, m_we, m_res_err;
   int            m_age, m_res_age;
   logic [AW-1:0] m_idx;
   logic [DW-1:0] m_wd, m_if_data, m_dm_data;
   logic          e_ifr, e_dmr, e_ce, e_we, e_burst, e_ifv, e_dmv, e_err, e_resp;
   logic [AW-1:0] e_idx;
   logic [DW-1:0] e_wd;

   initial begin
      forever begin
         @(negedge clk);
         e_ifr = 0; e_dmr = 0; e_ce = 0; e_idx = '0; e_we = 0; e_burst = 0;
         e_wd = '0; e_ifv = 0; e_dmv = 0; e_err = 0; e_resp = 0;
         if (model_on) begin
            if (!m_busy) begin
               if (rst_n && ddr_rdy) begin
                  if (if_valid && (!dm_valid || m_last_dm)) e_ifr = 1;
                  else if (dm_valid) e_dmr = 1;
               end
            end else if (m_res_age >= 0 && m_age == m_res_age + 1) begin
               e_resp = 1;
               if (rst_n) begin
                  e_ifv = !m_own_dm;
                  e_dmv = m_own_dm;
                  e_err = m_res_err;
               end
            end else begin
               e_ce    = (m_age == 1);
               e_idx   = m_idx;
               e_we    = m_we;
               e_burst = !m_own_dm;
               e_wd    = m_wd;
            end
            chk("if_req_ready", if_ready, e_ifr);
            chk("dm_req_ready", dm_ready, e_dmr);
            chk("ddr_chip_enable", d_ce, e_ce);
            chk("ddr_index", d_idx, e_idx);
            chk("ddr_write_enable", d_we, e_we);
            chk("ddr_burst_mode", d_burst, e_burst);
            chk("ddr_write_data", d_wdata, e_wd);
            chk("if_resp_valid", if_rv, e_ifv);
            chk("dm_resp_valid", dm_rv, e_dmv);
            chk("resp_err", r_err, e_err);
            chk("if_resp_data", if_rdata, m_if_data);
            chk("dm_resp_data", dm_rdata, m_dm_data);
         end
         if (if_ready) grant_q.push_back('{cyc, 1'b0});
         if (dm_ready) grant_q.push_back('{cyc, 1'b1});
         if (d_ce) ce_q.push_back('{cyc, d_idx, d_we, d_burst, d_wdata});
         if (if_rv) resp_q.push_back('{cyc, 1'b0, r_err, if_rdata});
         if (dm_rv) resp_q.push_back('{cyc, 1'b1, r_err, dm_rdata});
         if (!rst_n) begin
            model_on = 1; m_busy = 0; m_last_dm = 1; m_res_age = -1;
            m_if_data = '0; m_dm_data = '0;
         end else if (model_on) begin
            if (!m_busy) begin
               if (e_ifr || e_dmr) begin
                  m_busy = 1; m_age = 1; m_res_age = -1; m_own_dm = e_dmr;
                  m_idx = e_dmr ? dm_idx : if_idx;
                  m_we  = e_dmr && dm_write;
                  m_wd  = m_we ? dm_wdata : '0;
               end
            end else if (e_resp) begin
               m_busy = 0;
               m_last_dm = m_own_dm;
            end else begin
               if (m_age >= 2 && ddr_done) begin
                  m_res_age = m_age; m_res_err = 0;
                  if (m_own_dm) m_dm_data = m_we ? '0 : ddr_rdata;
                  else          m_if_data = ddr_rdata;
               end else if (m_age == TO + 1) begin
                  m_res_age = m_age; m_res_err = 1;
                  if (m_own_dm) m_dm_data = '0;
                  else          m_if_data = '0;
               end
               m_age++;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(input int base, input string nm);
      int k = 0;
      while (grant_q.size() <= base && k < 100) begin tick(1); k++; end
      chk({nm, "_grant_seen"}, grant_q.size() > base, 1);
   endtask

   task automatic wait_resp(input int base, input string nm);
      int k = 0;
      while (resp_q.size() <= base && k < 100) begin tick(1); k++; end
      chk({nm, "_resp_seen"}, resp_q.size() > base, 1);
   endtask

   task automatic run_req(input bit dm, input logic [AW-1:0] idx, input bit we,
                          input logic [DW-1:0] wd, input int lat, input string nm);
      int g0, r0;
      ddr_lat = lat;
      g0 = grant_q.size();
      r0 = resp_q.size();
      if (dm) begin dm_valid = 1; dm_idx = idx; dm_write = we; dm_wdata = wd; end
      else    begin if_valid = 1; if_idx = idx; end
      wait_grant(g0, nm);
      if_valid = 0; dm_valid = 0;
      wait_resp(r0, nm);
      tick(1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int g0, c0, r0, rr;
      rst_n = 0; ddr_rdy = 1;
      if_valid = 0; if_idx = '0; dm_valid = 0; dm_idx = '0; dm_write = 0; dm_wdata = '0;
      tick(3);
      rst_n = 1;
      tick(1);
      chk("reset_ce", d_ce, 0);
      chk("reset_if_data", if_rdata, 0);

      // 1: lone fetch read, DDR answers 5 cycles after CE
      r0 = resp_q.size();
      run_req(0, 64'h80, 0, '0, 5, "t1");
      chk("t1_ready_to_ce", ce_q[$].cyc - grant_q[$].cyc, 1);
      chk("t1_burst", ce_q[$].burst, 1);
      chk("t1_write", ce_q[$].we, 0);
      chk("t1_index", ce_q[$].idx, 64'h80);
      chk("t1_ce_to_resp", resp_q[$].cyc - ce_q[$].cyc, 6);
      chk("t1_resp_owner_if", resp_q[$].dm, 0);
      chk("t1_resp_count", resp_q.size() - r0, 1);
      chk("t1_data", resp_q[$].data, {8{64'h0123_4567_89AB_CD6F}});

      // 2: lone data write
      run_req(1, 64'h40, 1, {64{8'hA5}}, 3, "t2");
      chk("t2_write", ce_q[$].we, 1);
      chk("t2_burst", ce_q[$].burst, 0);
      chk("t2_wdata", ce_q[$].wd, {64{8'hA5}});
      chk("t2_index", ce_q[$].idx, 64'h40);
      chk("t2_resp_owner_dm", resp_q[$].dm, 1);
      chk("t2_resp_data_zero", resp_q[$].data, 0);
      chk("t2_resp_err", resp_q[$].err, 0);

      // 3: both requesters busy from reset -> strict alternation
      rst_n = 0; tick(2); rst_n = 1;
      ddr_lat = 2;
      g0 = grant_q.size(); c0 = ce_q.size(); r0 = resp_q.size();
      if_valid = 1; if_idx = 64'h1000;
      dm_valid = 1; dm_idx = 64'h2000; dm_write = 0;
      rr = 0;
      while (grant_q.size() < g0 + 4 && rr < 200) begin tick(1); rr++; end
      if_valid = 0; dm_valid = 0;
      chk("t3_four_grants", grant_q.size() >= g0 + 4, 1);
      for (int i = 0; i < 4; i++) begin
         if (grant_q.size() > g0 + i && ce_q.size() > c0 + i) begin
            chk($sformatf("t3_order_%0d", i), grant_q[g0+i].dm, (i % 2 == 1));
            chk($sformatf("t3_ce_lag_%0d", i), ce_q[c0+i].cyc - grant_q[g0+i].cyc, 1);
         end
      end
      rr = 0;
      while (resp_q.size() < r0 + 4 && rr < 100) begin tick(1); rr++; end
      chk("t3_four_resps", resp_q.size() - r0, 4);
      tick(2);

      // 4: DDR not ready holds all grants off
      g0 = grant_q.size(); c0 = ce_q.size(); r0 = resp_q.size();
      ddr_rdy = 0; if_valid = 1; if_idx = 64'h500; dm_valid = 1; dm_idx = 64'h600;
      tick(10);
      chk("t4_no_grant", grant_q.size() - g0, 0);
      chk("t4_no_ce", ce_q.size() - c0, 0);
      ddr_rdy = 1;
      rr = cyc;
      wait_grant(g0, "t4");
      if_valid = 0; dm_valid = 0;
      chk("t4_grant_cycle", grant_q[g0].cyc - rr, 0);
      chk("t4_grant_if", grant_q[g0].dm, 0);
      wait_resp(r0, "t4");
      tick(1);

      // 5: DDR never answers -> timeout after 8 WAIT cycles, then normal service
      run_req(1, 64'h100, 0, '0, 0, "t5a");
      chk("t5_ce_to_resp", resp_q[$].cyc - ce_q[$].cyc, 9);
      chk("t5_err", resp_q[$].err, 1);
      chk("t5_data_zero", resp_q[$].data, 0);
      chk("t5_owner_dm", resp_q[$].dm, 1);
      run_req(0, 64'h200, 0, '0, 3, "t5b");
      chk("t5b_err", resp_q[$].err, 0);
      chk("t5b_data", resp_q[$].data, pat(64'h200));
      chk("t5b_ce_to_resp", resp_q[$].cyc - ce_q[$].cyc, 4);

      // 6: reset during WAIT abandons the transaction
      ddr_lat = 0;
      g0 = grant_q.size(); c0 = ce_q.size(); r0 = resp_q.size();
      if_valid = 1; if_idx = 64'h300;
      wait_grant(g0, "t6");
      if_valid = 0;
      tick(3);
      rst_n = 0;
      tick(1);
      inject_done = 1;
      tick(1);
      rst_n = 1;
      tick(1);
      inject_done = 1;
      tick(3);
      chk("t6_no_resp", resp_q.size() - r0, 0);
      chk("t6_single_ce", ce_q.size() - c0, 1);
      chk("t6_ce_low", d_ce, 0);
      chk("t6_index_low", d_idx, 0);
      g0 = grant_q.size();
      ddr_lat = 3;
      if_valid = 1; if_idx = 64'h700; dm_valid = 1; dm_idx = 64'h800; dm_write = 0;
      wait_grant(g0, "t6b");
      if_valid = 0; dm_valid = 0;
      chk("t6_first_grant_if", grant_q[g0].dm, 0);
      wait_resp(r0, "t6b");
      tick(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
